// File: rtl/smem_req_router_if.sv
// Bundle of core-side and bank-side signals for the shared-memory request router.
// slave = router view, master = the agent driving cores and banks.
interface smem_req_router_if;
  logic [15:0]   core_req;
  logic [15:0]   core_we;
  logic [191:0]  core_addr;
  logic [127:0]  core_wdata;
  logic [15:0]   core_ack;
  logic [15:0]   core_err;
  logic [127:0]  core_rdata;
  logic [15:0]   core_busy;
  logic [255:0]  bk_read;
  logic [255:0]  bk_write;
  logic [191:0]  bk_addr;
  logic [127:0]  bk_wdata;
  logic [255:0]  bk_finish;
  logic [2047:0] bk_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, bk_finish, bk_rdata,
    output core_ack, core_err, core_rdata, core_busy, bk_read, bk_write, bk_addr, bk_wdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, bk_finish, bk_rdata,
    input  core_ack, core_err, core_rdata, core_busy, bk_read, bk_write, bk_addr, bk_wdata
  );
endinterface

// File: rtl/smem_req_router.sv
// Routes 16 independent core requests to 16 banks; one IDLE/PEND/DONE FSM per core
// with a per-core wait counter that abandons a request after TIMEOUT pending cycles.
module smem_req_router #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input logic             clock,
  input logic             reset,
  smem_req_router_if.slave bus
);
  localparam int unsigned NCORE = 16;
  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 8;

  typedef enum logic [1:0] {IDLE, PEND, DONE} state_e;

  state_e              state_q [NCORE];
  logic [7:0]          cnt_q   [NCORE];
  logic [NCORE-1:0]    we_q, ack_q, err_q, busy_q;
  logic [NCORE*AW-1:0] addr_q;
  logic [NCORE*DW-1:0] wdata_q, rdata_q;
  logic [255:0]        rd_q, wr_q;

  logic [3:0] req_bank [NCORE];
  logic [3:0] lat_bank [NCORE];

  // Bank field of the live request and of the latched request, per core
  always_comb begin
    for (int c = 0; c < NCORE; c++) begin
      req_bank[c] = bus.core_addr[c*AW+8 +: 4];
      lat_bank[c] = addr_q[c*AW+8 +: 4];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < NCORE; c++) begin
        state_q[c] <= IDLE;
        cnt_q[c]   <= 8'd0;
      end
      we_q    <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      busy_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      for (int c = 0; c < NCORE; c++) begin
        ack_q[c] <= 1'b0;
        err_q[c] <= 1'b0;
        unique case (state_q[c])
          IDLE: begin
            if (bus.core_req[c]) begin
              addr_q[c*AW +: AW]              <= bus.core_addr[c*AW +: AW];
              wdata_q[c*DW +: DW]             <= bus.core_wdata[c*DW +: DW];
              we_q[c]                         <= bus.core_we[c];
              cnt_q[c]                        <= 8'd0;
              busy_q[c]                       <= 1'b1;
              rd_q[{req_bank[c], 4'(c)}]      <= ~bus.core_we[c];
              wr_q[{req_bank[c], 4'(c)}]      <= bus.core_we[c];
              state_q[c]                      <= PEND;
            end
          end
          PEND: begin
            // Only the latched bank's finish counts; finish beats a same-cycle timeout
            if (bus.bk_finish[{lat_bank[c], 4'(c)}]) begin
              if (!we_q[c]) begin
                rdata_q[c*DW +: DW] <= bus.bk_rdata[{lat_bank[c], 4'(c), 3'b000} +: 8];
              end
              rd_q[{lat_bank[c], 4'(c)}] <= 1'b0;
              wr_q[{lat_bank[c], 4'(c)}] <= 1'b0;
              ack_q[c]                   <= 1'b1;
              state_q[c]                 <= DONE;
            end else if (cnt_q[c] == TIMEOUT - 8'd1) begin
              rd_q[{lat_bank[c], 4'(c)}] <= 1'b0;
              wr_q[{lat_bank[c], 4'(c)}] <= 1'b0;
              err_q[c]                   <= 1'b1;
              busy_q[c]                  <= 1'b0;
              state_q[c]                 <= IDLE;
            end else begin
              cnt_q[c] <= cnt_q[c] + 8'd1;
            end
          end
          DONE: begin
            busy_q[c]  <= 1'b0;
            state_q[c] <= IDLE;
          end
          default: state_q[c] <= IDLE;
        endcase
      end
    end
  end

  assign bus.core_ack   = ack_q;
  assign bus.core_err   = err_q;
  assign bus.core_busy  = busy_q;
  assign bus.core_rdata = rdata_q;
  assign bus.bk_read    = rd_q;
  assign bus.bk_write   = wr_q;
  assign bus.bk_addr    = addr_q;
  assign bus.bk_wdata   = wdata_q;
endmodule

// File: tb/tb_smem_req_router.sv
// Directed bench for smem_req_router: table of single-core transactions plus
// hand-written contention, timeout, stray-finish and reset sequences.
module tb_smem_req_router;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  smem_req_router_if bus ();

  smem_req_router #(.TIMEOUT(8'd10)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus.slave)
  );

  typedef struct {
    int         core;
    logic       we;
    logic [11:0] addr;
    logic [7:0] wdata;
    int         dly;
    logic [7:0] bdata;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] core_mask(input int c);
    logic [255:0] m;
    m = '0;
    for (int b = 0; b < 16; b++) m[b*16+c] = 1'b1;
    return m;
  endfunction

  function automatic logic [255:0] one_bit(input int idx);
    logic [255:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  task automatic issue(input int c, input logic we, input logic [11:0] addr, input logic [7:0] wd);
    bus.core_req[c]            = 1'b1;
    bus.core_we[c]             = we;
    bus.core_addr[c*12 +: 12]  = addr;
    bus.core_wdata[c*8 +: 8]   = wd;
  endtask

  task automatic finish(input int b, input int c, input logic [7:0] d);
    bus.bk_finish[b*16+c]        = 1'b1;
    bus.bk_rdata[b*128+c*8 +: 8] = d;
  endtask

  task automatic run_txn(input vec_t v);
    int c;
    int b;
    logic [11:0] gone;
    c = v.core;
    b = int'(v.addr[11:8]);
    issue(c, v.we, v.addr, v.wdata);
    step();
    bus.core_req[c] = 1'b0;
    // scramble live inputs; latched copies must not follow them
    gone = ~v.addr;
    bus.core_addr[c*12 +: 12] = gone;
    bus.core_wdata[c*8 +: 8]  = ~v.wdata;
    chk("txn_busy", 256'(bus.core_busy[c]), 256'(1'b1));
    chk("txn_rd_bits", bus.bk_read & core_mask(c), v.we ? 256'd0 : one_bit(b*16+c));
    chk("txn_wr_bits", bus.bk_write & core_mask(c), v.we ? one_bit(b*16+c) : 256'd0);
    chk("txn_bk_addr", 256'(bus.bk_addr[c*12 +: 12]), 256'(v.addr));
    chk("txn_bk_wdata", 256'(bus.bk_wdata[c*8 +: 8]), 256'(v.wdata));
    repeat (v.dly) step();
    chk("txn_no_early_ack", 256'(bus.core_ack[c]), 256'd0);
    finish(b, c, v.bdata);
    step();
    bus.bk_finish = '0;
    chk("txn_ack", 256'(bus.core_ack[c]), 256'(1'b1));
    chk("txn_err", 256'(bus.core_err[c]), 256'd0);
    chk("txn_done_bits", (bus.bk_read | bus.bk_write) & core_mask(c), 256'd0);
    chk("txn_rdata", 256'(bus.core_rdata[c*8 +: 8]), 256'(v.exp_rd));
    step();
    chk("txn_ack_drop", 256'(bus.core_ack[c]), 256'd0);
    chk("txn_busy_drop", 256'(bus.core_busy[c]), 256'd0);
  endtask

  initial begin
    //         core we   addr     wdata  dly bdata  exp_rd
    tbl[0] = '{3,  1'b0, 12'h5A7, 8'h00, 1, 8'hC4, 8'hC4};
    tbl[1] = '{0,  1'b1, 12'hF10, 8'h3E, 0, 8'h99, 8'h00};
    tbl[2] = '{0,  1'b0, 12'h0A0, 8'h00, 2, 8'h5B, 8'h5B};
    tbl[3] = '{0,  1'b1, 12'h3FF, 8'h11, 0, 8'h77, 8'h5B};
    tbl[4] = '{15, 1'b0, 12'hE01, 8'h00, 8, 8'h81, 8'h81};
    tbl[5] = '{7,  1'b0, 12'h2C3, 8'h00, 9, 8'hE6, 8'hE6};
    tbl[6] = '{10, 1'b1, 12'h1FF, 8'hA5, 3, 8'h42, 8'h00};

    bus.core_req   = '0;
    bus.core_we    = '0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    bus.bk_finish  = '0;
    bus.bk_rdata   = '0;

    repeat (2) step();
    rst = 1'b0;
    chk("rst_busy", 256'(bus.core_busy), 256'd0);
    chk("rst_ack", 256'(bus.core_ack), 256'd0);
    chk("rst_read", bus.bk_read, 256'd0);
    chk("rst_rdata", 256'(bus.core_rdata), 256'd0);

    for (int i = 0; i < 7; i++) run_txn(tbl[i]);

    // Two cores contend for bank 4; acks follow finish order
    issue(1, 1'b0, 12'h410, 8'h00);
    issue(2, 1'b0, 12'h420, 8'h00);
    step();
    bus.core_req = '0;
    chk("cont_rd", bus.bk_read & (core_mask(1) | core_mask(2)), one_bit(65) | one_bit(66));
    finish(4, 2, 8'h2A);
    step();
    bus.bk_finish = '0;
    chk("cont_ack2", 256'(bus.core_ack), 256'h0004);
    chk("cont_rd2", 256'(bus.core_rdata[23:16]), 256'h2A);
    finish(4, 1, 8'h1B);
    step();
    bus.bk_finish = '0;
    chk("cont_ack1", 256'(bus.core_ack), 256'h0002);
    chk("cont_rd1", 256'(bus.core_rdata[15:8]), 256'h1B);
    step();
    chk("cont_idle", 256'(bus.core_busy), 256'd0);

    // Timeout on core 4, then a late finish is ignored
    issue(4, 1'b0, 12'h300, 8'h00);
    step();
    bus.core_req = '0;
    repeat (9) step();
    chk("to_no_err_yet", 256'(bus.core_err), 256'd0);
    chk("to_busy_yet", 256'(bus.core_busy[4]), 256'(1'b1));
    step();
    chk("to_err", 256'(bus.core_err), 256'h0010);
    chk("to_busy_drop", 256'(bus.core_busy[4]), 256'd0);
    chk("to_no_ack", 256'(bus.core_ack), 256'd0);
    chk("to_rd_drop", bus.bk_read, 256'd0);
    finish(3, 4, 8'hFF);
    step();
    bus.bk_finish = '0;
    chk("to_err_pulse", 256'(bus.core_err), 256'd0);
    chk("to_late_fin", 256'(bus.core_ack), 256'd0);
    chk("to_late_busy", 256'(bus.core_busy), 256'd0);

    // Stray finish from another bank and a req while busy are both ignored
    issue(6, 1'b0, 12'h240, 8'h00);
    step();
    bus.core_req[6] = 1'b0;
    finish(9, 6, 8'h99);
    issue(6, 1'b1, 12'h5EE, 8'h77);
    step();
    bus.core_req  = '0;
    bus.bk_finish = '0;
    chk("stray_ack", 256'(bus.core_ack), 256'd0);
    chk("stray_busy", 256'(bus.core_busy[6]), 256'(1'b1));
    chk("stray_rd", bus.bk_read | bus.bk_write, one_bit(38));
    chk("stray_addr", 256'(bus.bk_addr[6*12 +: 12]), 256'h240);
    finish(2, 6, 8'h6E);
    step();
    bus.bk_finish = '0;
    chk("stray_fin_ack", 256'(bus.core_ack), 256'h0040);
    chk("stray_fin_rd", 256'(bus.core_rdata[55:48]), 256'h6E);
    step();

    // Reset mid-PEND abandons the request; later finish ignored; next request works
    issue(9, 1'b0, 12'h700, 8'h00);
    step();
    bus.core_req = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_busy", 256'(bus.core_busy), 256'd0);
    chk("mid_rd", bus.bk_read, 256'd0);
    chk("mid_rdata", 256'(bus.core_rdata), 256'd0);
    chk("mid_addr", 256'(bus.bk_addr), 256'd0);
    chk("mid_err", 256'(bus.core_err), 256'd0);
    finish(7, 9, 8'h55);
    step();
    bus.bk_finish = '0;
    chk("mid_late_ack", 256'(bus.core_ack), 256'd0);
    chk("mid_late_rdata", 256'(bus.core_rdata), 256'd0);
    run_txn('{9, 1'b0, 12'h700, 8'h00, 0, 8'h3C, 8'h3C});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
